ser_deser_rx: RTL and testbench

- Serial-to-parallel receiver: the receiving end of the serial stream produced by the team's universal shift register when it runs in left-shift or right-shift mode.
- Samples a serial bit on every strobe and assembles WIDTH-bit words, either MSB-first (left-shift source) or LSB-first (right-shift source).
- Presents each completed word on a valid/ready parallel port, with overrun and abort reporting.
- Sits between a serial link and a parallel consumer (register file, FIFO).

---
 rtl/ser_deser_rx.sv | 146 ++++++++++++++
 tb/tb_ser_deser_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_deser_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first
// from a strobed serial stream and hands them out on a valid/ready port.
module ser_deser_rx #(
  parameter int WIDTH = 8,
  parameter bit CONT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     dir,
  input  logic                     sen,
  input  logic                     sin,
  input  logic                     pready,
  input  logic                     clr_ovr,
  output logic [WIDTH-1:0]         pout,
  output logic                     pvalid,
  output logic                     busy,
  output logic [$clog2(WIDTH):0]   bit_cnt,
  output logic                     overrun,
  output logic                     abort
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_RECV = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_pout;
  logic             r_pvalid;
  logic             r_busy;
  logic             r_ovr;
  logic             r_abort;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_abort_nxt;
  logic [WIDTH-1:0] w_pout_nxt;
  logic             w_pvalid_nxt;
  logic             w_ovr_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;

  // The word as it stands once the current sin is shifted in.
  assign w_word     = r_dir ? {sin, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], sin};
  assign w_complete = (r_state == S_RECV) && !start && sen && (r_cnt == LAST);

  // Receive FSM: start (re)arms a word, sen shifts one bit.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_abort_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RECV;
          w_cnt_nxt   = {CW{1'b0}};
          w_dir_nxt   = dir;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RECV: begin
        if (start) begin
          w_abort_nxt = (r_cnt != {CW{1'b0}});
          w_cnt_nxt   = {CW{1'b0}};
          w_dir_nxt   = dir;
        end else if (sen) begin
          w_sh_nxt = w_word;
          if (r_cnt == LAST) begin
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = CONT ? S_RECV : S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // Output stage: a completed word replaces pout only if the slot is free
  // or being drained this cycle; otherwise it is dropped and flagged.
  always_comb begin
    w_pout_nxt   = r_pout;
    w_pvalid_nxt = r_pvalid;
    w_ovr_nxt    = clr_ovr ? 1'b0 : r_ovr;
    if (w_complete) begin
      if (!r_pvalid || pready) begin
        w_pout_nxt   = w_word;
        w_pvalid_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end else if (r_pvalid && pready) begin
      w_pvalid_nxt = 1'b0;
    end else begin
      w_pvalid_nxt = r_pvalid;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sh     <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_dir    <= 1'b0;
      r_pout   <= {WIDTH{1'b0}};
      r_pvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_ovr    <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sh     <= w_sh_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir    <= w_dir_nxt;
      r_pout   <= w_pout_nxt;
      r_pvalid <= w_pvalid_nxt;
      r_busy   <= (w_state_nxt == S_RECV);
      r_ovr    <= w_ovr_nxt;
      r_abort  <= w_abort_nxt;
    end
  end

  assign pout    = r_pout;
  assign pvalid  = r_pvalid;
  assign busy    = r_busy;
  assign bit_cnt = r_cnt;
  assign overrun = r_ovr;
  assign abort   = r_abort;

endmodule

// File: tb/tb_ser_deser_rx.sv
// Bench for ser_deser_rx: one single-shot and one continuous instance share
// stimulus and are compared against a bit-list reference model.
module tb_ser_deser_rx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n, start, dir, sen, sin, pready, clr_ovr;
  logic [W-1:0] d_pout [2];
  logic         d_pvalid [2];
  logic         d_busy [2];
  logic [3:0]   d_cnt [2];
  logic         d_ovr [2];
  logic         d_abort [2];

  int n_checks = 0;
  int n_err    = 0;

  int           m_recv [2];
  int           m_cnt [2];
  int           m_dir [2];
  int           m_pvalid [2];
  int           m_ovr [2];
  int           m_abort [2];
  logic [W-1:0] m_pout [2];
  int           m_bits [2][W];

  always #5 clk = ~clk;

  ser_deser_rx #(.WIDTH(W), .CONT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .sen(sen), .sin(sin),
    .pready(pready), .clr_ovr(clr_ovr), .pout(d_pout[0]), .pvalid(d_pvalid[0]),
    .busy(d_busy[0]), .bit_cnt(d_cnt[0]), .overrun(d_ovr[0]), .abort(d_abort[0]));

  ser_deser_rx #(.WIDTH(W), .CONT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .sen(sen), .sin(sin),
    .pready(pready), .clr_ovr(clr_ovr), .pout(d_pout[1]), .pvalid(d_pvalid[1]),
    .busy(d_busy[1]), .bit_cnt(d_cnt[1]), .overrun(d_ovr[1]), .abort(d_abort[1]));

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_recv[k] = 0; m_cnt[k] = 0; m_dir[k] = 0; m_pvalid[k] = 0;
      m_ovr[k] = 0; m_abort[k] = 0; m_pout[k] = '0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, then wait past the edge.
  task automatic step(input logic st, input logic d, input logic se,
                      input logic si, input logic pr, input logic cl);
    start = st; dir = d; sen = se; sin = si; pready = pr; clr_ovr = cl;
    for (int k = 0; k < 2; k++) begin
      bit done;
      bit drop;
      logic [W-1:0] word;
      done = 1'b0; drop = 1'b0; word = '0;
      m_abort[k] = (m_recv[k] != 0 && st && m_cnt[k] != 0) ? 1 : 0;
      if (st) begin
        m_recv[k] = 1; m_cnt[k] = 0; m_dir[k] = d;
      end else if (m_recv[k] != 0 && se) begin
        m_bits[k][m_cnt[k]] = si;
        m_cnt[k]++;
        if (m_cnt[k] == W) begin
          for (int i = 0; i < W; i++)
            if (m_bits[k][i] != 0)
              word = word | (m_dir[k] != 0 ? (W'(1) << i) : (W'(1) << (W - 1 - i)));
          done = 1'b1; m_cnt[k] = 0; m_recv[k] = k;
        end
      end
      if (done) begin
        if (m_pvalid[k] == 0 || pr) begin m_pout[k] = word; m_pvalid[k] = 1; end
        else drop = 1'b1;
      end else if (m_pvalid[k] != 0 && pr) begin
        m_pvalid[k] = 0;
      end
      if (drop) m_ovr[k] = 1;
      else if (cl) m_ovr[k] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic d, input logic [W-1:0] w,
                           input logic pr_last, input logic cl_last);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++)
      step(1'b0, d, 1'b1, d ? w[i] : w[W-1-i], (i == W-1) ? pr_last : 1'b0,
           (i == W-1) ? cl_last : 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; sen = 1'b0; sin = 1'b0;
    pready = 1'b0; clr_ovr = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (d_pout[k] !== '0 || d_pvalid[k] !== 1'b0 || d_busy[k] !== 1'b0 ||
          d_cnt[k] !== 4'd0 || d_ovr[k] !== 1'b0 || d_abort[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset k=%0d pout=%h pvalid=%b busy=%b cnt=%0d ovr=%b abort=%b expected all zero",
                 k, d_pout[k], d_pvalid[k], d_busy[k], d_cnt[k], d_ovr[k], d_abort[k]);
      end
    end
  endtask

  task automatic test_msb_first();
    send_word(1'b0, 8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (d_pout[0] !== 8'hA5 || d_pout[0] !== m_pout[0]) begin
      n_err++; $display("FAIL msb_pout got=%h exp=%h", d_pout[0], 8'hA5);
    end
    n_checks++;
    if (d_pvalid[0] !== 1'b1 || d_busy[0] !== 1'b0 || d_cnt[0] !== 4'd0) begin
      n_err++; $display("FAIL msb_flags pvalid=%b busy=%b cnt=%0d exp 1 0 0", d_pvalid[0], d_busy[0], d_cnt[0]);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (d_pvalid[0] !== 1'b0) begin
      n_err++; $display("FAIL msb_consume pvalid=%b exp 0", d_pvalid[0]);
    end
  endtask

  task automatic test_lsb_gap();
    logic [W-1:0] w;
    w = 8'hA5;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b0, 1'b1, w[i], 1'b0, 1'b0);
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
          n_checks++;
          if (d_cnt[0] !== 4'd4 || d_pvalid[0] !== 1'b0) begin
            n_err++; $display("FAIL lsb_gap cnt=%0d pvalid=%b exp 4 0", d_cnt[0], d_pvalid[0]);
          end
        end
      end
      if (i == W-2) begin
        n_checks++;
        if (d_pvalid[0] !== 1'b0) begin
          n_err++; $display("FAIL lsb_early_pvalid got=%b exp 0", d_pvalid[0]);
        end
      end
    end
    n_checks++;
    if (d_pvalid[0] !== 1'b1 || d_pout[0] !== 8'hA5 || d_pout[0] !== m_pout[0]) begin
      n_err++; $display("FAIL lsb_word pvalid=%b pout=%h exp 1 a5", d_pvalid[0], d_pout[0]);
    end
  endtask

  task automatic test_cont();
    logic [15:0] s;
    do_reset();
    s = 16'h3CC3;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, s[15-i], (i == 15) ? 1'b1 : 1'b0, 1'b0);
      n_checks++;
      if (d_busy[1] !== 1'b1 || d_ovr[1] !== 1'b0 || d_pvalid[1] !== ((i >= 7) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL cont_flags i=%0d busy=%b ovr=%b pvalid=%b", i, d_busy[1], d_ovr[1], d_pvalid[1]);
      end
      if (i == 7 || i == 15) begin
        n_checks++;
        if (d_pout[1] !== ((i == 7) ? 8'h3C : 8'hC3) || d_pout[1] !== m_pout[1]) begin
          n_err++; $display("FAIL cont_pout i=%0d got=%h exp=%h", i, d_pout[1], (i == 7) ? 8'h3C : 8'hC3);
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(1'b0, 8'h11, 1'b0, 1'b0);
    send_word(1'b0, 8'h22, 1'b0, 1'b0);
    n_checks++;
    if (d_pout[0] !== 8'h11 || d_ovr[0] !== 1'b1 || d_pvalid[0] !== 1'b1) begin
      n_err++; $display("FAIL ovr_drop pout=%h ovr=%b pvalid=%b exp 11 1 1", d_pout[0], d_ovr[0], d_pvalid[0]);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (d_ovr[0] !== 1'b0) begin
      n_err++; $display("FAIL ovr_clear got=%b exp 0", d_ovr[0]);
    end
    send_word(1'b0, 8'h33, 1'b0, 1'b1);
    n_checks++;
    if (d_ovr[0] !== 1'b1 || d_pout[0] !== 8'h11) begin
      n_err++; $display("FAIL ovr_set_wins ovr=%b pout=%h exp 1 11", d_ovr[0], d_pout[0]);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] w;
    w = 8'h5A;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (d_abort[0] !== 1'b1 || d_cnt[0] !== 4'd0 || d_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL abort_pulse abort=%b cnt=%0d busy=%b exp 1 0 1", d_abort[0], d_cnt[0], d_busy[0]);
    end
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b0, 1'b1, w[W-1-i], 1'b0, 1'b0);
      if (i == 0) begin
        n_checks++;
        if (d_abort[0] !== 1'b0) begin
          n_err++; $display("FAIL abort_width got=%b exp 0", d_abort[0]);
        end
      end
    end
    n_checks++;
    if (d_pout[0] !== 8'h5A || d_pvalid[0] !== 1'b1) begin
      n_err++; $display("FAIL abort_word pout=%h pvalid=%b exp 5a 1", d_pout[0], d_pvalid[0]);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (d_abort[0] !== 1'b0) begin
      n_err++; $display("FAIL abort_at_zero got=%b exp 0", d_abort[0]);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (d_pvalid[0] !== 1'b0 || d_pout[0] !== '0 || d_busy[0] !== 1'b0 ||
        d_cnt[0] !== 4'd0 || d_abort[0] !== 1'b0) begin
      n_err++; $display("FAIL async_reset pvalid=%b pout=%h busy=%b cnt=%0d abort=%b exp zeros",
                        d_pvalid[0], d_pout[0], d_busy[0], d_cnt[0], d_abort[0]);
    end
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (d_pout[k] !== m_pout[k] || d_pvalid[k] !== 1'(m_pvalid[k]) ||
            d_busy[k] !== 1'(m_recv[k]) || d_cnt[k] !== 4'(m_cnt[k]) ||
            d_ovr[k] !== 1'(m_ovr[k]) || d_abort[k] !== 1'(m_abort[k])) begin
          n_err++;
          $display("FAIL random c=%0d k=%0d got pout=%h v=%b b=%b n=%0d o=%b a=%b exp pout=%h v=%0d b=%0d n=%0d o=%0d a=%0d",
                   c, k, d_pout[k], d_pvalid[k], d_busy[k], d_cnt[k], d_ovr[k], d_abort[k],
                   m_pout[k], m_pvalid[k], m_recv[k], m_cnt[k], m_ovr[k], m_abort[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gap();
    test_cont();
    test_overrun();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
